// File: rtl/booth_multiplier_4bit.sv
// Sequential signed 4x4 radix-2 Booth multiplier with a start/busy/done handshake.
// One add/subtract step per cycle through an internal 4-bit adder/subtractor.

module adder_subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {4{sel}}} + {4'b0, sel};
    end

    assign s    = full[3:0];
    assign cout = full[4];
endmodule

module booth_multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] a, q, m;
    logic       q_1;
    logic [2:0] count;

    logic       sel, op;
    logic [3:0] s, sum;
    logic       cout, sign5;
    logic [3:0] a_nxt, q_nxt;

    assign sel = q[0] & ~q_1;
    assign op  = q[0] ^ q_1;

    adder_subtractor_4bit u_addsub (
        .a    (a),
        .b    (m),
        .sel  (sel),
        .s    (s),
        .cout (cout)
    );

    // sign5 is the 5th bit of the exact sum, so -8 operands and A-M overflow still shift correctly
    always_comb begin
        sum   = a;
        sign5 = a[3];
        if (op) begin
            sum   = s;
            sign5 = a[3] ^ (m[3] ^ sel) ^ cout;
        end
        a_nxt = {sign5, sum[3:1]};
        q_nxt = {sum[0], q[3:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == 3'd3) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    a     <= a_nxt;
                    q     <= q_nxt;
                    q_1   <= q[0];
                    count <= count + 3'd1;
                    if (count == 3'd3) product <= {a_nxt, q_nxt};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_multiplier_4bit.sv
// Scoreboard bench for booth_multiplier_4bit: stimulus pushes expected products,
// a monitor pops and compares on every done pulse.

module tb_booth_multiplier_4bit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_q[$];

    booth_multiplier_4bit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    task automatic mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_run", {7'b0, busy}, 8'd1);
            check("done_run", {7'b0, done}, 8'd0);
        end
        @(negedge clk);
        check("done_pulse", {7'b0, done}, 8'd1);
        check("busy_done", {7'b0, busy}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        multiplicand = 4'd3;
        multiplier = 4'd5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_done", {7'b0, done}, 8'd0);
        check("rst_product", product, 8'h00);

        mult(4'd3,  4'd5,  8'h0F);
        mult(4'hD,  4'd5,  8'hF1);
        mult(4'd5,  4'hD,  8'hF1);
        mult(4'd0,  4'h9,  8'h00);
        mult(4'h8,  4'h8,  8'h40);
        mult(4'd7,  4'h8,  8'hC8);
        mult(4'h8,  4'd7,  8'hC8);
        mult(4'hF,  4'hF,  8'h01);

        // second start while busy must be ignored
        @(negedge clk);
        multiplicand = 4'd2;
        multiplier   = 4'd3;
        start        = 1'b1;
        exp_q.push_back(8'h06);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 multiplicand = 4'd7;
        multiplier = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_ignore_product", product, 8'h06);
        check("busy_ignore_idle", {7'b0, busy}, 8'd0);

        // start held high: done every 5 cycles, product held between pulses
        @(negedge clk);
        multiplicand = 4'd2;
        multiplier   = 4'd3;
        start        = 1'b1;
        repeat (3) exp_q.push_back(8'h06);
        for (int unsigned i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("b2b_done", {7'b0, done}, {7'b0, (i % 5) == 0});
            check("b2b_busy", {7'b0, busy}, {7'b0, (i % 5) != 0});
            if (i >= 5) check("b2b_hold", product, 8'h06);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-operation discards the in-flight result
        @(negedge clk);
        multiplicand = 4'd5;
        multiplier   = 4'd5;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {7'b0, busy}, 8'd0);
        check("midrst_done", {7'b0, done}, 8'd0);
        check("midrst_product", product, 8'h00);
        repeat (6) @(negedge clk);
        check("midrst_still_zero", product, 8'h00);

        mult(4'hC, 4'd6, 8'hE8);
        repeat (3) @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
